// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory responder.
package mem_responder_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_state_t;

    localparam int          WAIT_W    = 4;
    localparam logic [31:0] RDATA_RST = 32'h0;

endpackage

// File: rtl/mem_responder_wait_ctr.sv
// Loadable down-counter that times the wait states between acceptance and response.
// o_zero is high when the count has reached zero.
module wait_ctr
    import mem_responder_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_load,
    input  logic [WAIT_W-1:0] i_load_val,
    input  logic              i_en,
    output logic              o_zero
);

    logic [WAIT_W-1:0] r_count;

    // Load takes priority over decrement, and the count saturates at zero.
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_count <= '0;
        else if (i_load)
            r_count <= i_load_val;
        else if (i_en && (r_count != '0))
            r_count <= r_count - 1'b1;
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/mem_responder.sv
// Unified instruction/data word memory with a valid/ready request/response
// handshake. Each access takes a fixed, parameterized number of wait states.
// Only one request is outstanding at a time.
// Optional feature: define MEM_MISALIGN_ERR_EN to flag requests with
// req_addr[1:0] != 0. Such requests get rsp_err=1, and a misaligned write is
// not committed to the array.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [WAIT_W-1:0] LOAD_VAL =
        (WAIT_CYCLES > 0) ? WAIT_W'(WAIT_CYCLES - 1) : '0;

    logic [31:0]   r_mem [DEPTH_WORDS];
    mem_state_t    r_state, w_next;
    logic [AW-1:0] r_idx, w_idx, w_rsp_idx;
    logic          r_we, r_err;
    logic          w_accept, w_misalign, w_rsp_we, w_rsp_err;
    logic          w_ctr_load, w_ctr_en, w_ctr_zero, w_enter_resp;
    logic          w_unused;

    // Upper address bits wrap onto the array.
    assign w_idx = req_addr[AW+1:2];

`ifdef MEM_MISALIGN_ERR_EN
    assign w_misalign = (req_addr[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_unused = &{1'b0, req_addr[31:AW+2], req_addr[1:0]};

    // req_ready is gated by reset so nothing is accepted while reset is held.
    assign req_ready = (r_state == IDLE) && !reset;
    assign w_accept  = req_valid && req_ready;

    // With zero wait states, RESP is entered on the acceptance edge itself.
    // The response then has to use the live request, not the latched copy.
    assign w_rsp_idx = (r_state == IDLE) ? w_idx      : r_idx;
    assign w_rsp_we  = (r_state == IDLE) ? req_we     : r_we;
    assign w_rsp_err = (r_state == IDLE) ? w_misalign : r_err;

    wait_ctr u_wait_ctr (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_load     (w_ctr_load),
        .i_load_val (LOAD_VAL),
        .i_en       (w_ctr_en),
        .o_zero     (w_ctr_zero)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Next-state logic, counter control, and the RESP entry strobe.
    always_comb begin
        w_next       = r_state;
        w_ctr_load   = 1'b0;
        w_ctr_en     = 1'b0;
        w_enter_resp = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (WAIT_CYCLES > 0) begin
                        w_next     = WAIT;
                        w_ctr_load = 1'b1;
                    end else begin
                        w_next       = RESP;
                        w_enter_resp = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (w_ctr_zero) begin
                    w_next       = RESP;
                    w_enter_resp = 1'b1;
                end else begin
                    w_ctr_en = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Latch the accepted request for use on a later RESP entry edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx <= '0;
            r_we  <= 1'b0;
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_idx <= w_idx;
            r_we  <= req_we;
            r_err <= w_misalign;
        end
    end

    // Writes commit at acceptance. The array is not reset, so a write survives a reset.
    always_ff @(posedge clk) begin
        if (w_accept && req_we && !w_misalign)
            r_mem[w_idx] <= req_wdata;
    end

    // Response registers: loaded on RESP entry, held until the handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= RDATA_RST;
            rsp_err   <= 1'b0;
        end else if (w_enter_resp) begin
            rsp_valid <= 1'b1;
            rsp_err   <= w_rsp_err;
            rsp_rdata <= (w_rsp_we || w_rsp_err) ? RDATA_RST : r_mem[w_rsp_idx];
        end else if ((r_state == RESP) && rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= RDATA_RST;
            rsp_err   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder. Index 0 is a WAIT_CYCLES=0 instance.
// Index 1 is a WAIT_CYCLES=2 instance.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset     [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    int vectors = 0;
    int errs    = 0;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .reset(reset[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full access. The task drives the request, measures latency and checks the response.
    // It optionally holds RESP for 'hold' cycles while presenting a request that must be ignored.
    // It then completes the handshake.
    task automatic do_req(input int s, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp_rd,
                          input int exp_lat, input logic exp_err, input int hold,
                          input string tag);
        int n;
        @(negedge clk);
        chk({tag, ".req_ready_idle"}, 32'(req_ready[s]), 32'd1);
        req_valid[s] = 1'b1; req_we[s] = we; req_addr[s] = addr; req_wdata[s] = wd;
        @(negedge clk);
        req_valid[s] = 1'b0;
        n = 1;
        while (!rsp_valid[s] && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".latency"}, 32'(n), 32'(exp_lat));
        chk({tag, ".rdata"}, rsp_rdata[s], exp_rd);
        chk({tag, ".err"}, 32'(rsp_err[s]), 32'(exp_err));
        chk({tag, ".req_ready_resp"}, 32'(req_ready[s]), 32'd0);
        for (int h = 0; h < hold; h++) begin
            req_valid[s] = 1'b1; req_we[s] = 1'b1; req_wdata[s] = 32'h0BADF00D;
            @(negedge clk);
            chk({tag, ".hold_valid"}, 32'(rsp_valid[s]), 32'd1);
            chk({tag, ".hold_rdata"}, rsp_rdata[s], exp_rd);
            chk({tag, ".hold_ready"}, 32'(req_ready[s]), 32'd0);
        end
        req_valid[s] = 1'b0;
        rsp_ready[s] = 1'b1;
        @(negedge clk);
        rsp_ready[s] = 1'b0;
        chk({tag, ".done_valid"}, 32'(rsp_valid[s]), 32'd0);
        chk({tag, ".done_rdata"}, rsp_rdata[s], 32'h0);
        chk({tag, ".done_ready"}, 32'(req_ready[s]), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            reset[i] = 1'b1; req_valid[i] = 1'b0; req_we[i] = 1'b0;
            req_addr[i] = '0; req_wdata[i] = '0; rsp_ready[i] = 1'b0;
        end

        // Reset state.
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst.req_ready", 32'(req_ready[i]), 32'd0);
            chk("rst.rsp_valid", 32'(rsp_valid[i]), 32'd0);
            chk("rst.rsp_rdata", rsp_rdata[i], 32'h0);
            chk("rst.rsp_err",   32'(rsp_err[i]), 32'd0);
            reset[i] = 1'b0;
        end
        @(negedge clk);
        chk("rst.ready_after0", 32'(req_ready[0]), 32'd1);
        chk("rst.ready_after2", 32'(req_ready[1]), 32'd1);

        // WAIT_CYCLES=2: write then read back.
        do_req(1, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0,        3, 1'b0, 0, "w2.wr10");
        do_req(1, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 3, 1'b0, 0, "w2.rd10");

        // WAIT_CYCLES=0: write then read back.
        do_req(0, 1'b1, 32'h00, 32'h12345678, 32'h0,        1, 1'b0, 0, "w0.wr00");
        do_req(0, 1'b0, 32'h00, 32'h0,        32'h12345678, 1, 1'b0, 0, "w0.rd00");

        // Stall in RESP for 5 cycles. The write presented meanwhile must be ignored.
        do_req(1, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 3, 1'b0, 5, "w2.hold");
        do_req(1, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 3, 1'b0, 0, "w2.noclobber");

        // Address wrap: 0x100 maps to word 0 in a 64-word array.
        do_req(1, 1'b1, 32'h100, 32'hA5A5A5A5, 32'h0,        3, 1'b0, 0, "wrap.wr");
        do_req(1, 1'b0, 32'h000, 32'h0,        32'hA5A5A5A5, 3, 1'b0, 0, "wrap.rd");

        // Misaligned write.
        do_req(1, 1'b1, 32'h20, 32'h55555555, 32'h0, 3, 1'b0, 0, "mis.prior");
`ifdef MEM_MISALIGN_ERR_EN
        do_req(1, 1'b1, 32'h22, 32'h11111111, 32'h0,        3, 1'b1, 0, "mis.wr");
        do_req(1, 1'b0, 32'h20, 32'h0,        32'h55555555, 3, 1'b0, 0, "mis.rd");
`else
        do_req(1, 1'b1, 32'h22, 32'h11111111, 32'h0,        3, 1'b0, 0, "mis.wr");
        do_req(1, 1'b0, 32'h20, 32'h0,        32'h11111111, 3, 1'b0, 0, "mis.rd");
`endif

        // Reset during WAIT of a read: no response may ever appear.
        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 32'h10;
        @(negedge clk);
        req_valid[1] = 1'b0;
        reset[1] = 1'b1;
        chk("mrst.ready_in_rst", 32'(req_ready[1]), 32'd0);
        @(negedge clk);
        chk("mrst.ready_idle_rst", 32'(req_ready[1]), 32'd0);
        reset[1] = 1'b0;
        @(negedge clk);
        chk("mrst.ready_after", 32'(req_ready[1]), 32'd1);
        begin
            int seen = 0;
            for (int k = 0; k < 6; k++) begin
                if (rsp_valid[1]) seen++;
                @(negedge clk);
            end
            chk("mrst.no_rsp", 32'(seen), 32'd0);
        end

        // A write accepted before the reset stays committed.
        do_req(1, 1'b0, 32'h000, 32'h0, 32'hA5A5A5A5, 3, 1'b0, 0, "mrst.mem_kept");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
